div_sub_sequencer_fsm: RTL and testbench

- Moore controller that sequences the shared register-file/ALU datapath through an unsigned repeated-subtraction divide.
- Computes R[QUO_REG] = dividend / divisor and R[REM_REG] = dividend % divisor.
- Drives the same mux-select, immediate, opcode and write-enable controls as the multiply sequencer, and reads back the ALU flags.
- A Start/Busy/Done handshake lets a top-level test harness or a later instruction decoder launch divides.

---
 rtl/alu_defs_pkg.sv | 48 ++++
 rtl/div_iter_counter.sv | 30 +++
 rtl/div_sub_sequencer_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_div_sub_sequencer_fsm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared ALU opcode, flag-index and sequencer state definitions for the
// register-file/ALU datapath controllers.
package alu_defs_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_XOR   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h09;
    localparam logic [7:0] OP_CMP   = 8'h0B;
    localparam logic [7:0] OP_ADDUI = 8'h60;
    localparam logic [7:0] OP_CMPI  = 8'hB0;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CLR_REM  = 4'd1,
        S_LD_REM   = 4'd2,
        S_CLR_DIV  = 4'd3,
        S_LD_DIV   = 4'd4,
        S_CLR_QUO  = 4'd5,
        S_CHK_ZERO = 4'd6,
        S_ZTEST    = 4'd7,
        S_CMP      = 4'd8,
        S_CTEST    = 4'd9,
        S_SUB      = 4'd10,
        S_INC      = 4'd11,
        S_DONE     = 4'd12
    } div_state_t;

    // Multiply sequencer states share this package so both controllers
    // agree on one datapath vocabulary.
    typedef enum logic [3:0] {
        M_IDLE     = 4'd0,
        M_CLR_ACC  = 4'd1,
        M_LD_MCAND = 4'd2,
        M_LD_MPLR  = 4'd3,
        M_CHK      = 4'd4,
        M_TEST     = 4'd5,
        M_ADD      = 4'd6,
        M_DEC      = 4'd7,
        M_DONE     = 4'd8
    } mul_state_t;

endpackage

// File: rtl/div_iter_counter.sv
// Subtraction counter for the divide sequencer, with the abort-limit compare.
module div_iter_counter
    import alu_defs_pkg::*;
#(
    parameter int          BIT_WIDTH = 16,
    parameter int unsigned MAX_ITER  = 16'hFFFF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 clear,
    input  logic                 inc,
    output logic [BIT_WIDTH-1:0] count,
    output logic                 at_max
);

    // NOTE: sequential state is always updated with <= so every flop samples
    // the pre-edge value regardless of process ordering.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == BIT_WIDTH'(MAX_ITER));

endmodule

// File: rtl/div_sub_sequencer_fsm.sv
// Moore controller driving the shared register-file/ALU datapath through an
// unsigned repeated-subtraction divide with a Start/Busy/Done handshake.
module div_sub_sequencer_fsm
    import alu_defs_pkg::*;
#(
    parameter int          BIT_WIDTH    = 16,
    parameter int          OPCODE_WIDTH = 8,
    parameter int          FLAG_WIDTH   = 5,
    parameter int          SEL_WIDTH    = 4,
    parameter int          REM_REG      = 0,
    parameter int          DIV_REG      = 1,
    parameter int          QUO_REG      = 2,
    parameter int unsigned MAX_ITER     = 16'hFFFF
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Start,
    input  logic [BIT_WIDTH-1:0]    Dividend,
    input  logic [BIT_WIDTH-1:0]    Divisor,
    input  logic [FLAG_WIDTH-1:0]   Flags,
    output logic [SEL_WIDTH-1:0]    Rsrc_mux_sel,
    output logic [SEL_WIDTH-1:0]    Rdest_mux_sel,
    output logic                    Imm_mux_sel,
    output logic [BIT_WIDTH-1:0]    Imm_val,
    output logic [OPCODE_WIDTH-1:0] Opcode,
    output logic [BIT_WIDTH-1:0]    Reg_File_En,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Div_By_Zero,
    output logic                    Overflow,
    output logic [BIT_WIDTH-1:0]    Iter_Count
);

    div_state_t           ps, ns;
    logic [BIT_WIDTH-1:0] dividend_q, divisor_q;
    logic                 accept, set_dbz, set_ovf;
    logic                 at_max;
    logic                 unused_flags;

    assign unused_flags = ^{Flags[FLAG_C], Flags[FLAG_F], Flags[FLAG_N]};

    function automatic logic [BIT_WIDTH-1:0] reg_bit(input int idx);
        return {{(BIT_WIDTH-1){1'b0}}, 1'b1} << idx;
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ps <= S_IDLE;
        end else begin
            ps <= ns;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dividend_q  <= '0;
            divisor_q   <= '0;
            Div_By_Zero <= 1'b0;
            Overflow    <= 1'b0;
        end else if (accept) begin
            dividend_q  <= Dividend;
            divisor_q   <= Divisor;
            Div_By_Zero <= 1'b0;
            Overflow    <= 1'b0;
        end else begin
            if (set_dbz) Div_By_Zero <= 1'b1;
            if (set_ovf) Overflow    <= 1'b1;
        end
    end

    div_iter_counter #(
        .BIT_WIDTH (BIT_WIDTH),
        .MAX_ITER  (MAX_ITER)
    ) u_iter (
        .Clk    (Clk),
        .Rst    (Rst),
        .clear  (accept),
        .inc    (ps == S_SUB),
        .count  (Iter_Count),
        .at_max (at_max)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        ns            = ps;
        accept        = 1'b0;
        set_dbz       = 1'b0;
        set_ovf       = 1'b0;
        Rsrc_mux_sel  = '0;
        Rdest_mux_sel = '0;
        Imm_mux_sel   = 1'b0;
        Imm_val       = '0;
        Opcode        = OPCODE_WIDTH'(OP_NOP);
        Reg_File_En   = '0;
        Done          = 1'b0;

        case (ps)
            S_IDLE: begin
                if (Start) begin
                    accept = 1'b1;
                    ns     = S_CLR_REM;
                end
            end
            S_CLR_REM: begin
                Opcode        = OPCODE_WIDTH'(OP_XOR);
                Rsrc_mux_sel  = SEL_WIDTH'(REM_REG);
                Rdest_mux_sel = SEL_WIDTH'(REM_REG);
                Reg_File_En   = reg_bit(REM_REG);
                ns            = S_LD_REM;
            end
            S_LD_REM: begin
                Opcode        = OPCODE_WIDTH'(OP_ADDUI);
                Rdest_mux_sel = SEL_WIDTH'(REM_REG);
                Imm_mux_sel   = 1'b1;
                Imm_val       = dividend_q;
                Reg_File_En   = reg_bit(REM_REG);
                ns            = S_CLR_DIV;
            end
            S_CLR_DIV: begin
                Opcode        = OPCODE_WIDTH'(OP_XOR);
                Rsrc_mux_sel  = SEL_WIDTH'(DIV_REG);
                Rdest_mux_sel = SEL_WIDTH'(DIV_REG);
                Reg_File_En   = reg_bit(DIV_REG);
                ns            = S_LD_DIV;
            end
            S_LD_DIV: begin
                Opcode        = OPCODE_WIDTH'(OP_ADDUI);
                Rdest_mux_sel = SEL_WIDTH'(DIV_REG);
                Imm_mux_sel   = 1'b1;
                Imm_val       = divisor_q;
                Reg_File_En   = reg_bit(DIV_REG);
                ns            = S_CLR_QUO;
            end
            S_CLR_QUO: begin
                Opcode        = OPCODE_WIDTH'(OP_XOR);
                Rsrc_mux_sel  = SEL_WIDTH'(QUO_REG);
                Rdest_mux_sel = SEL_WIDTH'(QUO_REG);
                Reg_File_En   = reg_bit(QUO_REG);
                ns            = S_CHK_ZERO;
            end
            S_CHK_ZERO: begin
                Opcode        = OPCODE_WIDTH'(OP_CMPI);
                Rdest_mux_sel = SEL_WIDTH'(DIV_REG);
                Imm_mux_sel   = 1'b1;
                ns            = S_ZTEST;
            end
            // Flags from a compare are registered, so they are read one state later.
            S_ZTEST: begin
                if (Flags[FLAG_Z]) begin
                    set_dbz = 1'b1;
                    ns      = S_DONE;
                end else begin
                    ns      = S_CMP;
                end
            end
            S_CMP: begin
                Opcode        = OPCODE_WIDTH'(OP_CMP);
                Rsrc_mux_sel  = SEL_WIDTH'(DIV_REG);
                Rdest_mux_sel = SEL_WIDTH'(REM_REG);
                ns            = S_CTEST;
            end
            S_CTEST: begin
                if (Flags[FLAG_L]) begin
                    ns      = S_DONE;
                end else if (at_max) begin
                    set_ovf = 1'b1;
                    ns      = S_DONE;
                end else begin
                    ns      = S_SUB;
                end
            end
            S_SUB: begin
                Opcode        = OPCODE_WIDTH'(OP_SUB);
                Rsrc_mux_sel  = SEL_WIDTH'(DIV_REG);
                Rdest_mux_sel = SEL_WIDTH'(REM_REG);
                Reg_File_En   = reg_bit(REM_REG);
                ns            = S_INC;
            end
            S_INC: begin
                Opcode        = OPCODE_WIDTH'(OP_ADDUI);
                Rdest_mux_sel = SEL_WIDTH'(QUO_REG);
                Imm_mux_sel   = 1'b1;
                Imm_val       = BIT_WIDTH'(1);
                Reg_File_En   = reg_bit(QUO_REG);
                ns            = S_CMP;
            end
            S_DONE: begin
                Done = 1'b1;
                ns   = S_IDLE;
            end
            default: begin
                ns = S_IDLE;
            end
        endcase
    end

    assign Busy = (ps != S_IDLE);

endmodule

// File: tb/tb_div_sub_sequencer_fsm.sv
// Self-checking bench: two sequencers (default limit and MAX_ITER = 4), each
// driving a behavioural register-file/ALU model, checked against plain arithmetic.
module tb_div_sub_sequencer_fsm;

    localparam logic [7:0] T_NOP   = 8'h00;
    localparam logic [7:0] T_XOR   = 8'h03;
    localparam logic [7:0] T_SUB   = 8'h09;
    localparam logic [7:0] T_CMP   = 8'h0B;
    localparam logic [7:0] T_ADDUI = 8'h60;
    localparam logic [7:0] T_CMPI  = 8'hB0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // DUT A: default MAX_ITER
    logic        start_a = 1'b0;
    logic [15:0] dd_a = '0, dv_a = '0;
    logic [4:0]  flags_a = '0;
    logic [3:0]  rsrc_a, rdest_a;
    logic        imm_sel_a, busy_a, done_a, dbz_a, ovf_a;
    logic [15:0] imm_a, en_a, iter_a;
    logic [7:0]  op_a;

    // DUT B: MAX_ITER = 4
    logic        start_b = 1'b0;
    logic [15:0] dd_b = '0, dv_b = '0;
    logic [4:0]  flags_b = '0;
    logic [3:0]  rsrc_b, rdest_b;
    logic        imm_sel_b, busy_b, done_b, dbz_b, ovf_b;
    logic [15:0] imm_b, en_b, iter_b;
    logic [7:0]  op_b;

    div_sub_sequencer_fsm u_dut_a (
        .Clk(clk), .Rst(rst), .Start(start_a), .Dividend(dd_a), .Divisor(dv_a),
        .Flags(flags_a), .Rsrc_mux_sel(rsrc_a), .Rdest_mux_sel(rdest_a),
        .Imm_mux_sel(imm_sel_a), .Imm_val(imm_a), .Opcode(op_a), .Reg_File_En(en_a),
        .Busy(busy_a), .Done(done_a), .Div_By_Zero(dbz_a), .Overflow(ovf_a),
        .Iter_Count(iter_a)
    );

    div_sub_sequencer_fsm #(.MAX_ITER(4)) u_dut_b (
        .Clk(clk), .Rst(rst), .Start(start_b), .Dividend(dd_b), .Divisor(dv_b),
        .Flags(flags_b), .Rsrc_mux_sel(rsrc_b), .Rdest_mux_sel(rdest_b),
        .Imm_mux_sel(imm_sel_b), .Imm_val(imm_b), .Opcode(op_b), .Reg_File_En(en_b),
        .Busy(busy_b), .Done(done_b), .Div_By_Zero(dbz_b), .Overflow(ovf_b),
        .Iter_Count(iter_b)
    );

    // Behavioural datapath: register file, ALU and registered compare flags.
    logic [15:0] rf_a [16];
    logic [15:0] rf_b [16];
    logic [15:0] ob_a, ob_b;
    int          subs_a = 0, subs_b = 0;

    assign ob_a = imm_sel_a ? imm_a : rf_a[rsrc_a];
    assign ob_b = imm_sel_b ? imm_b : rf_b[rsrc_b];

    function automatic logic [15:0] alu_res(input logic [7:0] op, input logic [15:0] d, input logic [15:0] b);
        case (op)
            T_XOR:   return d ^ b;
            T_SUB:   return d - b;
            T_ADDUI: return d + b;
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        if (op_a == T_CMP || op_a == T_CMPI)
            flags_a <= {1'b0, rf_a[rdest_a] == ob_a, 1'b0, rf_a[rdest_a] < ob_a, 1'b0};
        for (int i = 0; i < 16; i++)
            if (en_a[i]) rf_a[i] <= alu_res(op_a, rf_a[rdest_a], ob_a);
        if (op_a == T_SUB) subs_a <= subs_a + 1;
    end

    always @(posedge clk) begin
        if (op_b == T_CMP || op_b == T_CMPI)
            flags_b <= {1'b0, rf_b[rdest_b] == ob_b, 1'b0, rf_b[rdest_b] < ob_b, 1'b0};
        for (int i = 0; i < 16; i++)
            if (en_b[i]) rf_b[i] <= alu_res(op_b, rf_b[rdest_b], ob_b);
        if (op_b == T_SUB) subs_b <= subs_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Launch one divide (caller is at a negedge with the DUT idle), wait for
    // Done, and compare everything against arithmetic expectations.
    task automatic run_div(input bit use_b, input logic [15:0] dd, input logic [15:0] dv,
                           input int glitch_at, input string name);
        int unsigned m, q, eq, er, cyc;
        bit          e_dbz, e_ovf, seen;
        int          c, subs0;

        m     = use_b ? 4 : 65535;
        e_dbz = 1'b0;
        e_ovf = 1'b0;
        if (dv == 0) begin
            e_dbz = 1'b1;
            eq    = 0;
            er    = dd;
            cyc   = 8;
        end else begin
            q = dd / dv;
            if (q > m) begin
                e_ovf = 1'b1;
                eq    = m;
                er    = dd - m * dv;
            end else begin
                eq = q;
                er = dd % dv;
            end
            cyc = 10 + 4 * eq;
        end

        subs0 = use_b ? subs_b : subs_a;
        if (use_b) begin start_b = 1'b1; dd_b = dd; dv_b = dv; end
        else       begin start_a = 1'b1; dd_a = dd; dv_a = dv; end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;

        c    = 1;
        seen = 1'b0;
        while (!seen && c <= int'(cyc) + 20) begin
            @(negedge clk);
            if (use_b ? done_b : done_a) begin
                seen = 1'b1;
            end else begin
                if (!use_b && c == glitch_at) begin
                    start_a = 1'b1; dd_a = 16'd100; dv_a = 16'd1;
                end else begin
                    start_a = 1'b0;
                end
                c++;
            end
        end
        start_a = 1'b0;

        check({name, ".done_cycle"}, seen ? 32'(c) : 32'hFFFF_FFFF, cyc);
        if (!seen) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            return;
        end
        check({name, ".rem"},  use_b ? rf_b[0] : rf_a[0], er);
        check({name, ".quo"},  use_b ? rf_b[2] : rf_a[2], eq);
        check({name, ".iter"}, use_b ? iter_b : iter_a, eq);
        check({name, ".dbz"},  use_b ? dbz_b : dbz_a, e_dbz);
        check({name, ".ovf"},  use_b ? ovf_b : ovf_a, e_ovf);
        check({name, ".subs"}, 32'((use_b ? subs_b : subs_a) - subs0), eq);
        @(negedge clk);
        check({name, ".done_pulse"}, use_b ? done_b : done_a, 0);
        check({name, ".idle"},       use_b ? busy_b : busy_a, 0);
    endtask

    task automatic run_reset_abort();
        start_a = 1'b1; dd_a = 16'd17; dv_a = 16'd5;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        check("abort.busy_before", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort.busy",   busy_a, 0);
        check("abort.en",     en_a, 0);
        check("abort.opcode", op_a, T_NOP);
        check("abort.done",   done_a, 0);
        check("abort.iter",   iter_a, 0);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] rdv, rdd;
        int unsigned rq;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset.busy",   busy_a, 0);
        check("reset.done",   done_a, 0);
        check("reset.en",     en_a, 0);
        check("reset.opcode", op_a, T_NOP);
        check("reset.iter",   iter_a, 0);
        check("reset.dbz",    dbz_a, 0);
        check("reset.ovf",    ovf_b, 0);

        run_div(1'b0, 16'd17, 16'd5, -1, "d17_5");
        run_div(1'b0, 16'd3,  16'd7, -1, "d3_7");
        run_div(1'b0, 16'd9,  16'd0, -1, "d9_0");
        run_div(1'b0, 16'd17, 16'd5,  5, "d17_5_glitch");
        run_div(1'b0, 16'd9,  16'd0, -1, "d9_0_again");
        run_reset_abort();
        run_div(1'b0, 16'hFFFF, 16'hFFFF, -1, "b2b_max");
        run_div(1'b0, 16'd0,    16'd1,    -1, "b2b_zero");

        run_div(1'b1, 16'd20, 16'd1, -1, "lim_20_1");
        run_div(1'b1, 16'd12, 16'd3, -1, "lim_12_3");
        run_div(1'b1, 16'd7,  16'd0, -1, "lim_7_0");

        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                rdv = 16'd0;
                rdd = 16'($urandom);
            end else begin
                rdv = 16'($urandom_range(1, 3000));
                rq  = $urandom_range(0, 20);
                rdd = 16'(rq * rdv + $urandom_range(0, rdv - 1));
            end
            run_div(k[0], rdd, rdv, -1, $sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
